wave_trig_capture: RTL

Trigger-and-capture buffer between the ADC/DA-loopback sample mux and the HDMI waveform renderer.
- Decimates incoming 8-bit samples by the horizontal-scale factor and arms on a level/edge trigger.
- Stores one DEPTH-sample frame around the trigger point, with PRE_TRIG samples of pre-history.
- Presents the frame on a trigger-aligned random-access read port, so the trace stays stable on screen instead of free-running.

---
 rtl/wave_trig_capture.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/wave_trig_capture.sv
// wave_trig_capture
// Trigger-and-capture buffer between the sample mux and the waveform renderer.
// Incoming samples are decimated, written into a circular RAM, and a level/edge
// trigger freezes one frame with PRE_TRIG samples of history. The renderer reads
// the frozen frame through a trigger-aligned logical address (0 = oldest sample).
module wave_trig_capture #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 128,
    parameter int TIMEOUT  = 1048576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_in_i,
    input  logic [2:0]        decim_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic              trig_edge_i,
    input  logic              frame_ack_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              frame_ready_o,
    output logic              trig_forced_o,
    output logic              busy_o
);

    // Samples written from the trigger sample (inclusive) to the end of the frame.
    localparam int POST_LEN = DEPTH - PRE_TRIG;
    // Pre/post counters must be able to hold DEPTH itself.
    localparam int CNT_W    = ADDR_W + 1;
    // Timeout counter is wide enough to hold TIMEOUT and saturates there.
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] wp_q,       wp_d;
    logic [ADDR_W-1:0] start_q,    start_d;
    logic [CNT_W-1:0]  pre_cnt_q,  pre_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic [2:0]        dec_cnt_q,  dec_cnt_d;
    logic [DATA_W-1:0] prev_q,     prev_d;
    logic              prev_ok_q,  prev_ok_d;
    logic              ready_q,    ready_d;
    logic              forced_q,   forced_d;
    logic [DATA_W-1:0] rd_data_q;

    // Frame storage: simple dual-port RAM, no reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic [2:0]        dec_max;
    logic              capturing;
    logic              restart;
    logic              accept;
    logic              rise_hit;
    logic              fall_hit;
    logic              edge_hit;
    logic [TO_W-1:0]   to_cnt_inc;
    logic              to_hit;
    logic [CNT_W-1:0]  pre_cnt_inc;
    logic [CNT_W-1:0]  post_cnt_inc;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_phys;

    // Decimation, trigger detection and counter increments.
    always_comb begin
        // decim=0 behaves like decim=1: every valid sample is kept.
        dec_max      = (decim_i == 3'd0) ? 3'd0 : (decim_i - 3'd1);
        capturing    = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
        restart      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && frame_ack_i);
        accept       = capturing && sample_valid_i && (dec_cnt_q == dec_max);
        rise_hit     = (prev_q < trig_level_i) && (trig_level_i <= sample_in_i);
        fall_hit     = (prev_q >= trig_level_i) && (trig_level_i > sample_in_i);
        // The first kept sample in ARMED only seeds prev and can never trigger.
        edge_hit     = prev_ok_q && (trig_edge_i ? fall_hit : rise_hit);
        to_cnt_inc   = (to_cnt_q >= TO_W'(TIMEOUT)) ? to_cnt_q : (to_cnt_q + TO_W'(1));
        to_hit       = (to_cnt_inc >= TO_W'(TIMEOUT));
        pre_cnt_inc  = pre_cnt_q + CNT_W'(1);
        post_cnt_inc = post_cnt_q + CNT_W'(1);
        // Logical frame index 0 is the oldest sample, which sits at start_q.
        rd_phys      = start_q + rd_addr_i;
    end

    // Next-state logic for the capture FSM, pointers, counters and flags.
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        start_d    = start_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        to_cnt_d   = to_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        prev_d     = prev_q;
        prev_ok_d  = prev_ok_q;
        ready_d    = ready_q;
        forced_d   = forced_q;
        wr_en      = 1'b0;

        if (!enable_i) begin
            // Disable wins over everything; RAM contents are left alone.
            state_d = ST_IDLE;
            ready_d = 1'b0;
        end else if (restart) begin
            // Fresh frame: from IDLE on enable, or from DONE once the consumer acks.
            state_d    = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
            wp_d       = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            to_cnt_d   = '0;
            dec_cnt_d  = '0;
            prev_ok_d  = 1'b0;
            ready_d    = 1'b0;
            forced_d   = 1'b0;
        end else if (capturing) begin
            if (sample_valid_i) begin
                dec_cnt_d = accept ? 3'd0 : (dec_cnt_q + 3'd1);
            end
            if (accept) begin
                wr_en = 1'b1;
                wp_d  = wp_q + ADDR_W'(1);
                case (state_q)
                    ST_PRE: begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == CNT_W'(PRE_TRIG)) begin
                            state_d   = ST_ARMED;
                            prev_ok_d = 1'b0;
                            to_cnt_d  = '0;
                        end
                    end
                    ST_ARMED: begin
                        prev_d    = sample_in_i;
                        prev_ok_d = 1'b1;
                        to_cnt_d  = to_cnt_inc;
                        if (edge_hit || to_hit) begin
                            // A real edge in the same sample as the timeout is not forced.
                            start_d    = wp_q - ADDR_W'(PRE_TRIG);
                            forced_d   = ~edge_hit;
                            post_cnt_d = CNT_W'(1);
                            if (POST_LEN == 1) begin
                                state_d = ST_DONE;
                                ready_d = 1'b1;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                    default: begin
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == CNT_W'(POST_LEN)) begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end
                    end
                endcase
            end
        end else if (state_q != ST_DONE) begin
            // Unused encodings fall back to IDLE.
            state_d = ST_IDLE;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            start_q    <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            to_cnt_q   <= '0;
            dec_cnt_q  <= '0;
            prev_q     <= '0;
            prev_ok_q  <= 1'b0;
            ready_q    <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            start_q    <= start_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            to_cnt_q   <= to_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            ready_q    <= ready_d;
            forced_q   <= forced_d;
        end
    end

    // RAM write port: every kept sample while capturing goes to wp.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wp_q] <= sample_in_i;
        end
    end

    // RAM read port: registered, one cycle after rd_addr, in every state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_phys];
        end
    end

    assign rd_data_o     = rd_data_q;
    assign frame_ready_o = ready_q;
    assign trig_forced_o = forced_q;
    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
